// File: rtl/mem_bus_arbiter_if.sv
// Requester and slave-side bus signals for the two-port memory bus arbiter.
// The arbiter takes the slave view; the environment (cores, memories) takes the master view.
interface mem_bus_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic        if_err_o;

  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_be_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic        dm_err_o;

  logic [31:0] rdata_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_we_o;
  logic [31:0] bus_rdata_i;
  logic        en_ram_o;
  logic        en_leds_o;
  logic        en_7_seg_lcd_o;
  logic        en_buttons_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
    input  bus_rdata_i,
    output if_gnt_o, if_rvalid_o, if_err_o,
    output dm_gnt_o, dm_rvalid_o, dm_err_o,
    output rdata_o, bus_addr_o, bus_wdata_o, bus_be_o, bus_we_o,
    output en_ram_o, en_leds_o, en_7_seg_lcd_o, en_buttons_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, dm_be_i,
    output bus_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_err_o,
    input  dm_gnt_o, dm_rvalid_o, dm_err_o,
    input  rdata_o, bus_addr_o, bus_wdata_o, bus_be_o, bus_we_o,
    input  en_ram_o, en_leds_o, en_7_seg_lcd_o, en_buttons_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between instruction fetch and data port on the shared memory bus,
// with region decode, programmable wait states and unmapped-address error responses.
module mem_bus_arbiter #(
    parameter int IO_WAIT  = 1,
    parameter int RAM_WAIT = 0
) (
    input logic clk_i,
    input logic rst_ni,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP, S_ERR} state_t;

    localparam logic [3:0] IO_W  = 4'(IO_WAIT);
    localparam logic [3:0] RAM_W = 4'(RAM_WAIT);

    state_t      state;
    logic        rdy;
    logic        last_dm;
    logic        owner_dm;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [3:0]  en_q;       // {buttons, 7seg, leds, ram}
    logic [3:0]  cnt;
    logic        bus_we_q;
    logic        if_rv_q, dm_rv_q, if_err_q, dm_err_q;

    function automatic logic [3:0] decode(input logic [31:0] a);
        decode = 4'b0000;
        if (a[31:29] == 3'b100)          decode = 4'b0001;
        else if (a[31:12] == 20'h50000)  decode = 4'b0010;
        else if (a[31:12] == 20'h60000)  decode = 4'b0100;
        else if (a[31:12] == 20'h70000)  decode = 4'b1000;
    endfunction

    logic        pick_if;
    logic        idle_go;
    logic [31:0] req_addr;
    logic [3:0]  req_region;
    logic        req_we;
    logic [3:0]  wait_sel;

    // IF wins when alone or when DM had the previous grant
    assign pick_if    = bus.if_req_i && (!bus.dm_req_i || last_dm);
    assign idle_go    = (state == S_IDLE) && rdy && (bus.if_req_i || bus.dm_req_i);
    assign req_addr   = pick_if ? bus.if_addr_i : bus.dm_addr_i;
    assign req_region = decode(req_addr);
    assign req_we     = !pick_if && bus.dm_we_i;
    assign wait_sel   = en_q[0] ? RAM_W : IO_W;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            rdy      <= 1'b0;
            last_dm  <= 1'b1;
            owner_dm <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            en_q     <= '0;
            cnt      <= '0;
            bus_we_q <= 1'b0;
            if_rv_q  <= 1'b0;
            dm_rv_q  <= 1'b0;
            if_err_q <= 1'b0;
            dm_err_q <= 1'b0;
        end else begin
            rdy <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (idle_go) begin
                        owner_dm <= !pick_if;
                        last_dm  <= !pick_if;
                        addr_q   <= req_addr & 32'hFFFF_FFFC;
                        we_q     <= req_we;
                        wdata_q  <= pick_if ? 32'h0 : bus.dm_wdata_i;
                        be_q     <= req_we ? bus.dm_be_i : 4'hF;
                        if (|req_region) begin
                            state    <= S_ACCESS;
                            en_q     <= req_region;
                            bus_we_q <= req_we;
                        end else begin
                            state    <= S_ERR;
                            if_rv_q  <= pick_if;
                            dm_rv_q  <= !pick_if;
                            if_err_q <= pick_if;
                            dm_err_q <= !pick_if;
                        end
                    end
                end
                S_ACCESS: begin
                    bus_we_q <= 1'b0;
                    cnt      <= wait_sel;
                    if (wait_sel != 4'd0) begin
                        state <= S_WAIT;
                    end else begin
                        state   <= S_RESP;
                        if_rv_q <= !owner_dm;
                        dm_rv_q <= owner_dm;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= S_RESP;
                        if_rv_q <= !owner_dm;
                        dm_rv_q <= owner_dm;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    en_q    <= '0;
                    if_rv_q <= 1'b0;
                    dm_rv_q <= 1'b0;
                end
                S_ERR: begin
                    state    <= S_IDLE;
                    if_rv_q  <= 1'b0;
                    dm_rv_q  <= 1'b0;
                    if_err_q <= 1'b0;
                    dm_err_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.if_gnt_o       = idle_go && pick_if;
    assign bus.dm_gnt_o       = idle_go && !pick_if;
    assign bus.if_rvalid_o    = if_rv_q;
    assign bus.dm_rvalid_o    = dm_rv_q;
    assign bus.if_err_o       = if_err_q;
    assign bus.dm_err_o       = dm_err_q;
    // Store responses return zero; the slave's read bus is only forwarded for loads/fetches
    assign bus.rdata_o        = (state == S_RESP && !we_q) ? bus.bus_rdata_i : 32'h0;
    assign bus.bus_addr_o     = addr_q;
    assign bus.bus_wdata_o    = wdata_q;
    assign bus.bus_be_o       = be_q;
    assign bus.bus_we_o       = bus_we_q;
    assign bus.en_ram_o       = en_q[0];
    assign bus.en_leds_o      = en_q[1];
    assign bus.en_7_seg_lcd_o = en_q[2];
    assign bus.en_buttons_o   = en_q[3];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected responses are queued at grant
// and retired when rvalid appears; one instance at IO_WAIT=1, one at IO_WAIT=3.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bus_arbiter_if b1();
  mem_bus_arbiter_if b3();
  logic [31:0] slave_rdata = 32'h0;
  logic [31:0] slave3 = 32'h0;
  assign b1.bus_rdata_i = slave_rdata;
  assign b3.bus_rdata_i = slave3;

  mem_bus_arbiter #(.IO_WAIT(1), .RAM_WAIT(0)) u_dut  (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));
  mem_bus_arbiter #(.IO_WAIT(3), .RAM_WAIT(0)) u_dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(b3.slave));

  typedef struct {
    logic        dm;
    logic        err;
    logic [31:0] rdata;
    int          gcyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  logic glog[$];
  int   gcy[$];
  exp_t mon_e;

  int n_chk = 0, n_pass = 0;
  int n_ram = 0, n_leds = 0, n_seg = 0, n_btn = 0, n_we = 0, n_multi = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int n_en();
    return n_ram + n_leds + n_seg + n_btn;
  endfunction

  // Monitor on the falling edge: region/strobe counters and scoreboard retirement
  always @(negedge clk) begin
    if (b1.en_ram_o)       n_ram  <= n_ram + 1;
    if (b1.en_leds_o)      n_leds <= n_leds + 1;
    if (b1.en_7_seg_lcd_o) n_seg  <= n_seg + 1;
    if (b1.en_buttons_o)   n_btn  <= n_btn + 1;
    if (b1.bus_we_o)       n_we   <= n_we + 1;
    if ($countones({b1.en_ram_o, b1.en_leds_o, b1.en_7_seg_lcd_o, b1.en_buttons_o}) > 1)
      n_multi <= n_multi + 1;
    if (b1.if_rvalid_o || b1.dm_rvalid_o) begin
      if (sb.size() == 0) begin
        chk("spurious_rvalid", 32'({b1.if_rvalid_o, b1.dm_rvalid_o}), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid_owner", 32'({b1.if_rvalid_o, b1.dm_rvalid_o}), mon_e.dm ? 32'h1 : 32'h2);
        chk("rsp_err", 32'({b1.if_err_o, b1.dm_err_o}),
            mon_e.err ? (mon_e.dm ? 32'h1 : 32'h2) : 32'h0);
        chk("rsp_rdata", b1.rdata_o, mon_e.rdata);
        chk("rsp_latency", 32'(cyc - mon_e.gcyc), 32'(mon_e.lat));
      end
    end
  end

  // Raise a request, wait (bounded) for its grant, queue the expected response.
  task automatic issue(input logic dm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int lat);
    int n = 0;
    exp_t e;
    if (dm) begin
      b1.dm_req_i = 1'b1; b1.dm_we_i = we; b1.dm_addr_i = addr;
      b1.dm_wdata_i = wdata; b1.dm_be_i = be;
    end else begin
      b1.if_req_i = 1'b1; b1.if_addr_i = addr;
    end
    @(negedge clk);
    while (!(dm ? b1.dm_gnt_o : b1.if_gnt_o) && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (n >= 60) begin
      chk(dm ? "dm_gnt_timeout" : "if_gnt_timeout", 32'h0, 32'h1);
    end else begin
      e.dm = dm; e.err = (lat == 1);
      e.rdata = (we || lat == 1) ? 32'h0 : slave_rdata;
      e.gcyc = cyc; e.lat = lat;
      sb.push_back(e);
      glog.push_back(dm);
      gcy.push_back(cyc);
      @(posedge clk); #1;
    end
    if (dm) begin b1.dm_req_i = 1'b0; b1.dm_we_i = 1'b0; end
    else b1.if_req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] t_addr [7] = '{32'h7000_1000, 32'h6FFF_FFFC, 32'h9FFF_FFFC, 32'h7FFF_FFFC,
                              32'h6000_0FFC, 32'h5000_1000, 32'h4FFF_FFFC};
  int          t_lat  [7] = '{1, 1, 2, 1, 3, 1, 1};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, l0, w0, e0, b0, g, rv_n, rv_lat;
    logic [31:0] rv_data;
    logic        rv_err;

    b1.if_req_i = 1'b1; b1.if_addr_i = 32'h8000_0000;
    b1.dm_req_i = 1'b1; b1.dm_we_i = 1'b0; b1.dm_addr_i = 32'h8000_0100;
    b1.dm_wdata_i = 32'h0; b1.dm_be_i = 4'hF;
    b3.if_req_i = 1'b0; b3.if_addr_i = 32'h0;
    b3.dm_req_i = 1'b0; b3.dm_we_i = 1'b0; b3.dm_addr_i = 32'h0;
    b3.dm_wdata_i = 32'h0; b3.dm_be_i = 4'h0;

    // Reset state with both requests pending
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'({b1.if_gnt_o, b1.dm_gnt_o}), 32'h0);
    chk("rst_ctl", 32'({b1.if_rvalid_o, b1.dm_rvalid_o, b1.if_err_o, b1.dm_err_o, b1.bus_we_o,
                        b1.en_ram_o, b1.en_leds_o, b1.en_7_seg_lcd_o, b1.en_buttons_o}), 32'h0);
    chk("rst_be", 32'(b1.bus_be_o), 32'h0);
    chk("rst_addr", b1.bus_addr_o, 32'h0);
    chk("rst_rdata", b1.rdata_o, 32'h0);

    // Both requesters held from reset: IF, DM, IF, DM with a fixed 3-cycle spacing
    @(posedge clk); #1;
    rst_n = 1'b1;
    slave_rdata = 32'h1111_2222;
    fork
      begin issue(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 2); issue(1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'hF, 2); end
      begin issue(1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF, 2); issue(1'b1, 1'b0, 32'h8000_0104, 32'h0, 4'hF, 2); end
    join
    idle(4);
    chk("rr_count", 32'(glog.size()), 32'd4);
    if (glog.size() == 4) begin
      chk("rr_order", 32'({glog[0], glog[1], glog[2], glog[3]}), 32'b0101);
      for (int i = 0; i < 3; i++) chk("rr_gap", 32'(gcy[i+1] - gcy[i]), 32'd3);
    end

    // IF fetch from RAM
    r0 = n_ram;
    slave_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 2);
    chk("if_en_ram", 32'(b1.en_ram_o), 32'h1);
    chk("if_bus_addr", b1.bus_addr_o, 32'h8000_0010);
    chk("if_bus_be", 32'(b1.bus_be_o), 32'hF);
    idle(4);
    chk("if_ram_cycles", 32'(n_ram - r0), 32'd2);

    // Fetch ignores stale DM store fields
    b1.dm_we_i = 1'b1; b1.dm_be_i = 4'h3; b1.dm_wdata_i = 32'hFFFF_FFFF;
    issue(1'b0, 1'b0, 32'h8000_0020, 32'h0, 4'hF, 2);
    chk("if_no_we", 32'(b1.bus_we_o), 32'h0);
    chk("if_be_full", 32'(b1.bus_be_o), 32'hF);
    chk("if_wdata", b1.bus_wdata_o, 32'h0);
    b1.dm_we_i = 1'b0;
    idle(4);

    // DM store to LEDs: one write strobe, response with zero data
    l0 = n_leds; w0 = n_we;
    slave_rdata = 32'h1234_5678;
    issue(1'b1, 1'b1, 32'h5000_0004, 32'h0000_00A5, 4'h1, 3);
    chk("st_we", 32'(b1.bus_we_o), 32'h1);
    chk("st_en_leds", 32'(b1.en_leds_o), 32'h1);
    chk("st_wdata", b1.bus_wdata_o, 32'h0000_00A5);
    chk("st_be", 32'(b1.bus_be_o), 32'h1);
    chk("st_addr", b1.bus_addr_o, 32'h5000_0004);
    idle(5);
    chk("st_we_cycles", 32'(n_we - w0), 32'd1);
    chk("st_leds_cycles", 32'(n_leds - l0), 32'd3);

    // Unmapped load and store: error response, no enables, no strobe
    e0 = n_en(); w0 = n_we;
    issue(1'b1, 1'b0, 32'hA000_0000, 32'h0, 4'hF, 1);
    idle(3);
    issue(1'b1, 1'b1, 32'h0000_0000, 32'h5A5A_5A5A, 4'hF, 1);
    idle(3);
    chk("unmapped_en", 32'(n_en() - e0), 32'd0);
    chk("unmapped_we", 32'(n_we - w0), 32'd0);

    // Region boundaries
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, 1'b0, t_addr[i], 32'h0, 4'hF, t_lat[i]);
      idle(4);
    end

    // Low address bits are dropped on the bus
    issue(1'b1, 1'b0, 32'h8000_0013, 32'h0, 4'hF, 2);
    chk("addr_align", b1.bus_addr_o, 32'h8000_0010);
    idle(4);

    // Buttons load on the IO_WAIT=3 instance
    slave3 = 32'hCAFE_0001;
    b3.dm_req_i = 1'b1; b3.dm_addr_i = 32'h7000_0FFC; b3.dm_we_i = 1'b0;
    g = 0;
    @(negedge clk);
    while (!b3.dm_gnt_o && g < 60) begin g++; @(negedge clk); end
    chk("btn_gnt_seen", 32'(b3.dm_gnt_o), 32'h1);
    g = cyc;
    @(posedge clk); #1;
    b3.dm_req_i = 1'b0;
    b0 = 0; rv_n = 0; rv_lat = 0; rv_data = 32'h0; rv_err = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b3.en_buttons_o) b0++;
      if (b3.dm_rvalid_o) begin
        rv_n++; rv_lat = cyc - g; rv_data = b3.rdata_o; rv_err = b3.dm_err_o;
      end
    end
    chk("btn_en_cycles", 32'(b0), 32'd5);
    chk("btn_rvalid_count", 32'(rv_n), 32'd1);
    chk("btn_latency", 32'(rv_lat), 32'd5);
    chk("btn_rdata", rv_data, 32'hCAFE_0001);
    chk("btn_err", 32'(rv_err), 32'h0);

    // Reset during WAIT of an I/O load aborts it silently
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 32'h7000_0000, 32'h0, 4'hF, 3);
    @(posedge clk); #1;
    chk("pre_rst_wait", 32'({b1.en_buttons_o, b1.dm_rvalid_o}), 32'b10);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 32'({b1.if_rvalid_o, b1.dm_rvalid_o, b1.if_err_o, b1.dm_err_o, b1.bus_we_o,
                              b1.en_ram_o, b1.en_leds_o, b1.en_7_seg_lcd_o, b1.en_buttons_o}), 32'h0);
    chk("async_rst_be", 32'(b1.bus_be_o), 32'h0);
    chk("async_rst_addr", b1.bus_addr_o, 32'h0);
    sb.delete();
    glog.delete();
    gcy.delete();
    b1.if_req_i = 1'b1; b1.if_addr_i = 32'h8000_0040;
    b1.dm_req_i = 1'b1; b1.dm_addr_i = 32'h8000_0080;
    repeat (3) @(negedge clk);
    chk("rst_hold_gnt", 32'({b1.if_gnt_o, b1.dm_gnt_o}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    slave_rdata = 32'h0BAD_F00D;
    fork
      issue(1'b0, 1'b0, 32'h8000_0040, 32'h0, 4'hF, 2);
      issue(1'b1, 1'b0, 32'h8000_0080, 32'h0, 4'hF, 2);
    join
    idle(4);
    chk("post_rst_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("post_rst_order", 32'({glog[0], glog[1]}), 32'b01);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("onehot_en", 32'(n_multi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory-mapped bus of the multicycle RISC-V core between two requesters: instruction fetch (IF, read-only) and data load/store (DM).
- Arbitrates between them round-robin, decodes the target region and drives the one-hot region enables.
- Sequences each access through a small FSM with programmable I/O wait states, and returns read data, write acknowledges and unmapped-address errors to the requester that owns the transaction.

Parameters:
- IO_WAIT, 1, extra wait cycles for LEDs, 7-seg and buttons accesses; 0..15 legal.
- RAM_WAIT, 0, extra wait cycles for RAM accesses; 0..15 legal.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- if_req_i  in  1  fetch request; held until if_gnt_o
- if_addr_i  in  32  fetch byte address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch response valid (1-cycle pulse)
- if_err_o  out  1  fetch hit an unmapped address; valid with if_rvalid_o
- dm_req_i  in  1  data request; held until dm_gnt_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  32  data byte address
- dm_wdata_i  in  32  store data
- dm_be_i  in  4  store byte enables
- dm_gnt_o  out  1  data request accepted (1-cycle pulse)
- dm_rvalid_o  out  1  data response valid, for loads and stores (1-cycle pulse)
- dm_err_o  out  1  data access hit an unmapped address; valid with dm_rvalid_o
- rdata_o  out  32  response read data, shared; meaningful only with an rvalid
- bus_addr_o  out  32  latched address, bits [1:0] forced to 0
- bus_wdata_o  out  32  latched store data
- bus_be_o  out  4  latched byte enables (4'hF for loads and fetches)
- bus_we_o  out  1  write strobe
- bus_rdata_i  in  32  read data from the selected slave
- en_ram_o, en_leds_o, en_7_seg_lcd_o, en_buttons_o  out  1 each  one-hot region enables

Behaviour:
- Address map:
  - RAM 0x8000_0000–0x9FFF_FFFF
  - LEDs 0x5000_0000–0x5000_0FFF
  - 7-seg 0x6000_0000–0x6000_0FFF
  - buttons 0x7000_0000–0x7000_0FFF
  - everything else unmapped
- FSM states: IDLE, ACCESS, WAIT, RESP, ERR.
- IDLE:
  - If any req is high, grant one requester: its gnt_o is driven high combinationally in this cycle.
  - Latch owner, address, we, wdata and be.
  - Next state is ACCESS if the address is mapped, else ERR.
  - No req: stay in IDLE, all outputs 0.
- Arbitration: if only one requester asks, it wins. If both ask, the one not granted last wins. last_grant resets to DM, so IF wins the first contest.
- ACCESS (one cycle):
  - Region enable for the latched address = 1; bus_addr_o/bus_wdata_o/bus_be_o valid.
  - bus_we_o = latched we. It is asserted only in this cycle, so each store is exactly one write strobe.
  - Load the wait counter with RAM_WAIT or IO_WAIT. Next state is WAIT if that value is nonzero, else RESP.
- WAIT:
  - Region enable held, bus_we_o = 0.
  - Counter decrements every cycle; leave for RESP in the cycle the counter reaches 1.
- RESP (one cycle):
  - Region enable held. Owner's rvalid_o = 1.
  - rdata_o = bus_rdata_i for loads and fetches, 0 for stores.
  - Next state is IDLE.
- ERR (one cycle):
  - No region enable, no bus_we_o.
  - Owner's rvalid_o = 1, err_o = 1, rdata_o = 0.
  - Next state is IDLE.
- Latency from grant to rvalid:
  - 2 + wait cycles for mapped accesses (RAM_WAIT=0 → 2, I/O with IO_WAIT=1 → 3).
  - 1 cycle for unmapped accesses.
  - At least 1 IDLE cycle separates consecutive transactions.
- Grants occur only in IDLE. While busy, both gnt_o are 0. A requester waiting during a busy period is served at the next IDLE, subject to round-robin.
- At most one region enable is high in any cycle. The region enables, bus_we_o, all gnt_o/rvalid_o/err_o and rdata_o are registered or state-decoded; only gnt_o is combinational.
- dm_we_i/dm_wdata_i/dm_be_i are ignored for IF. Fetches always use be = 4'hF and we = 0.
- Reset:
  - Async assertion at any time, including mid-transaction, forces IDLE.
  - All outputs go to 0 immediately, except bus_be_o, which becomes 4'h0.
  - last_grant returns to DM.
  - An aborted transaction produces no rvalid.
  - On deassertion, the first grant occurs no earlier than the first clock edge with rst_ni high.

Test Plan:
- IF load from 0x8000_0010, RAM_WAIT=0, bus_rdata_i=0xDEAD_BEEF:
  - if_gnt_o in cycle 0.
  - en_ram_o=1 and bus_addr_o=0x8000_0010 in cycles 1–2.
  - if_rvalid_o=1 with rdata_o=0xDEAD_BEEF in cycle 2.
- DM store 0x0000_00A5, be=4'h1 to 0x5000_0004, IO_WAIT=1:
  - bus_we_o=1 and en_leds_o=1 for exactly one cycle.
  - dm_rvalid_o in cycle 3 with rdata_o=0, dm_err_o=0.
- Both reqs held continuously from reset, targets in RAM: grants alternate IF, DM, IF, DM; no back-to-back grants without an IDLE gap.
- DM load from unmapped 0xA000_0000:
  - dm_rvalid_o=1 and dm_err_o=1 one cycle after grant.
  - No region enable asserted at any point.
- DM load from 0x7000_0FFC (buttons), IO_WAIT=3:
  - en_buttons_o high for 5 cycles.
  - dm_rvalid_o in cycle 5 after grant.
  - Addresses 0x7000_1000 and 0x6FFF_FFFC return errors.
- Assert rst_ni low during WAIT of an I/O load:
  - All outputs 0 immediately; no rvalid follows.
  - After release with both reqs high, IF is granted first.
